// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared encodings for the multi-cycle RV32I control path: opcode constants,
// branch func3 codes, main FSM state enum, ALUOp encoding (shared with the
// ALU controller), datapath mux select encodings and the opcode -> ImmSrc
// decode helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EX_R,
        S_EX_I,
        S_LUI,
        S_ALU_WB,
        S_JALR,
        S_JUMP,
        S_BRANCH
    } state_t;

    // ALUOp encoding, decoded further by the ALU controller
    localparam logic [1:0] LS_W = 2'd0;  // load/store address: ADD
    localparam logic [1:0] B_T  = 2'd1;  // branch compare: SUB
    localparam logic [1:0] RI_T = 2'd2;  // R/I type: func3/func7 decoded
    localparam logic [1:0] U_T  = 2'd3;  // LUI: pass immediate

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_REG   = 2'd2;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            OP_LUI:    imm = IMM_U;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_main_controller_branch_cond.sv
// branch_cond
// Combinational branch resolution from func3 and the ALU flags of the SUB
// performed in the BRANCH cycle.
// Configuration macro: BRANCH_EXT_EN -- when defined, bne/blt/bge are resolved;
// otherwise only beq can be taken and every other func3 is not taken.
// Ports:
//   func3  in  3  branch condition field of the IR
//   zero   in  1  ALU result == 0
//   neg    in  1  ALU result MSB (raw, overflow ignored)
//   taken  out 1  branch taken
module branch_cond
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);

`ifdef BRANCH_EXT_EN
    always_comb begin
        taken = 1'b0;
        case (func3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = neg;
            F3_BGE:  taken = !neg;
            default: taken = 1'b0;
        endcase
    end
`else
    // neg has no consumer without the extended branch set
    logic unused_neg;
    assign unused_neg = neg;

    always_comb begin
        taken = 1'b0;
        if (func3 == F3_BEQ)
            taken = zero;
    end
`endif

endmodule

// File: rtl/multicycle_main_controller.sv
// multicycle_main_controller
// Main control FSM of the multi-cycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/write-back and drives the datapath
// selects and enables plus the 2-bit ALUOp for the ALU controller.
// Configuration macro: BRANCH_EXT_EN (consumed by branch_cond) enables
// bne/blt/bge; without it only beq can be taken.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   opcode, func3       IR fields (stable from DECODE onward)
//   zero, neg           ALU flags used in the BRANCH cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite      enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp        datapath selects
//   instr_done          pulse in the last cycle of a retired instruction
//   illegal             pulse in DECODE for an unsupported opcode
//
// state     | meaning
// ----------+---------------------------------------------------------
// FETCH     | read IMEM at PC, load IR/OldPC, PC <- PC+4
// DECODE    | ALUOut <- OldPC+imm (branch/JAL target), dispatch on opcode
// MEM_ADR   | ALUOut <- rs1+imm (load/store address)
// MEM_RD    | read data memory at ALUOut
// MEM_WB    | rd <- memory data
// MEM_WR    | write data memory at ALUOut
// EX_R      | ALU rs1 op rs2
// EX_I      | ALU rs1 op imm
// LUI       | ALU passes U immediate
// ALU_WB    | rd <- ALUOut
// JALR      | ALUOut <- rs1+imm (jump target)
// JUMP      | PC <- ALUOut, ALU computes OldPC+4 for the link
// BRANCH    | SUB rs1-rs2, PC <- ALUOut when taken
module multicycle_main_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal
);

    state_t state, state_nxt;
    logic   br_taken;

    branch_cond u_branch_cond (
        .func3 (func3),
        .zero  (zero),
        .neg   (neg),
        .taken (br_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    // Outputs are gated by rst so that a reset mid-instruction kills any
    // pending write in the same cycle, and FETCH outputs stay low while
    // reset is held.
    always_comb begin
        state_nxt  = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_I;
        RegWrite   = 1'b0;
        ALUOp      = LS_W;
        instr_done = 1'b0;
        illegal    = 1'b0;

        if (!rst) begin
            ImmSrc = imm_src_of(opcode);
            case (state)
                S_FETCH: begin
                    AdrSrc    = 1'b0;
                    IRWrite   = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ALUOp     = LS_W;
                    ResultSrc = RES_ALU;
                    PCWrite   = 1'b1;
                    state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = LS_W;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                        OP_RTYPE:          state_nxt = S_EX_R;
                        OP_ITYPE:          state_nxt = S_EX_I;
                        OP_BRANCH:         state_nxt = S_BRANCH;
                        OP_JAL:            state_nxt = S_JUMP;
                        OP_JALR:           state_nxt = S_JALR;
                        OP_LUI:            state_nxt = S_LUI;
                        default: begin
                            state_nxt = S_FETCH;
                            illegal   = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADR: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_IMM;
                    ALUOp     = LS_W;
                    state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = RES_ALUOUT;
                    state_nxt = S_MEM_WB;
                end
                S_MEM_WB: begin
                    ResultSrc  = RES_MEM;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEM_WR: begin
                    AdrSrc     = 1'b1;
                    ResultSrc  = RES_ALUOUT;
                    MemWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_EX_R: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_REG;
                    ALUOp     = RI_T;
                    state_nxt = S_ALU_WB;
                end
                S_EX_I: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_IMM;
                    ALUOp     = RI_T;
                    state_nxt = S_ALU_WB;
                end
                S_LUI: begin
                    ALUSrcB   = SRCB_IMM;
                    ALUOp     = U_T;
                    state_nxt = S_ALU_WB;
                end
                S_ALU_WB: begin
                    ResultSrc  = RES_ALUOUT;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_JALR: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_IMM;
                    ALUOp     = LS_W;
                    state_nxt = S_JUMP;
                end
                S_JUMP: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ALUOp     = LS_W;
                    ResultSrc = RES_ALUOUT;
                    PCWrite   = 1'b1;
                    state_nxt = S_ALU_WB;
                end
                S_BRANCH: begin
                    ALUSrcA    = SRCA_REG;
                    ALUSrcB    = SRCB_REG;
                    ALUOp      = B_T;
                    ResultSrc  = RES_ALUOUT;
                    PCWrite    = br_taken;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// tb_multicycle_main_controller
// Table-driven check of the main control FSM: each record gives one
// instruction's IR fields and ALU flags plus the expected output word for
// every cycle of that instruction. Hand-written sequences cover reset hold
// and reset asserted in the middle of a store.
// Output word layout (18 bits, MSB first):
//   PCWrite AdrSrc MemWrite IRWrite ResultSrc[2] ALUSrcA[2] ALUSrcB[2]
//   ImmSrc[3] RegWrite ALUOp[2] instr_done illegal
module tb_multicycle_main_controller;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       zero;
    logic       neg;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    int compared;
    int mismatched;

`ifdef BRANCH_EXT_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    multicycle_main_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func3      (func3),
        .zero       (zero),
        .neg        (neg),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic rw,
                                       input logic [1:0] aop, input logic done,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, aop, done, ill};
    endfunction

    // Expected words per state, written straight from the state/output table
    function automatic logic [17:0] w_fetch(input logic [2:0] im);
        return mk(1, 0, 0, 1, 2, 0, 2, im, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] w_decode(input logic [2:0] im, input logic ill);
        return mk(0, 0, 0, 0, 0, 1, 1, im, 0, 0, 0, ill);
    endfunction
    function automatic logic [17:0] w_memadr(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2, 1, im, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] w_memrd(input logic [2:0] im);
        return mk(0, 1, 0, 0, 0, 0, 0, im, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] w_memwb(input logic [2:0] im);
        return mk(0, 0, 0, 0, 1, 0, 0, im, 1, 0, 1, 0);
    endfunction
    function automatic logic [17:0] w_memwr(input logic [2:0] im);
        return mk(0, 1, 1, 0, 0, 0, 0, im, 0, 0, 1, 0);
    endfunction
    function automatic logic [17:0] w_exr(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2, 0, im, 0, 2, 0, 0);
    endfunction
    function automatic logic [17:0] w_exi(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2, 1, im, 0, 2, 0, 0);
    endfunction
    function automatic logic [17:0] w_lui(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 0, 1, im, 0, 3, 0, 0);
    endfunction
    function automatic logic [17:0] w_aluwb(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 0, 0, im, 1, 0, 1, 0);
    endfunction
    function automatic logic [17:0] w_jalr(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2, 1, im, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] w_jump(input logic [2:0] im);
        return mk(1, 0, 0, 0, 0, 1, 2, im, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] w_branch(input logic taken);
        return mk(taken, 0, 0, 0, 0, 2, 0, 3'd2, 0, 1, 1, 0);
    endfunction

    typedef struct {
        string            name;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic             z;
        logic             n;
        int               ncyc;
        logic [4:0][17:0] exp;
    } vec_t;

    vec_t vecs[20];
    int   nv;

    task automatic push(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic n, input int ncyc,
                        input logic [17:0] e0, input logic [17:0] e1,
                        input logic [17:0] e2, input logic [17:0] e3,
                        input logic [17:0] e4);
        vecs[nv].name   = name;
        vecs[nv].op     = op;
        vecs[nv].f3     = f3;
        vecs[nv].z      = z;
        vecs[nv].n      = n;
        vecs[nv].ncyc   = ncyc;
        vecs[nv].exp[0] = e0;
        vecs[nv].exp[1] = e1;
        vecs[nv].exp[2] = e2;
        vecs[nv].exp[3] = e3;
        vecs[nv].exp[4] = e4;
        nv++;
    endtask

    function automatic logic [17:0] got_word();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegWrite, ALUOp, instr_done, illegal};
    endfunction

    task automatic check(input string name, input int cyc, input logic [17:0] exp);
        logic [17:0] got;
        got = got_word();
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %05h expected %05h", name, cyc, got, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        nv         = 0;

        push("lw",        7'b0000011, 3'b010, 0, 0, 5, w_fetch(0), w_decode(0, 0), w_memadr(0), w_memrd(0), w_memwb(0));
        push("sw",        7'b0100011, 3'b010, 0, 0, 4, w_fetch(1), w_decode(1, 0), w_memadr(1), w_memwr(1), '0);
        push("rtype",     7'b0110011, 3'b000, 0, 0, 4, w_fetch(0), w_decode(0, 0), w_exr(0), w_aluwb(0), '0);
        push("itype",     7'b0010011, 3'b000, 0, 0, 4, w_fetch(0), w_decode(0, 0), w_exi(0), w_aluwb(0), '0);
        push("lui",       7'b0110111, 3'b000, 0, 0, 4, w_fetch(4), w_decode(4, 0), w_lui(4), w_aluwb(4), '0);
        push("jal",       7'b1101111, 3'b000, 0, 0, 4, w_fetch(3), w_decode(3, 0), w_jump(3), w_aluwb(3), '0);
        push("jalr",      7'b1100111, 3'b000, 0, 0, 5, w_fetch(0), w_decode(0, 0), w_jalr(0), w_jump(0), w_aluwb(0));
        push("beq_z1",    7'b1100011, 3'b000, 1, 0, 3, w_fetch(2), w_decode(2, 0), w_branch(1), '0, '0);
        push("beq_z0",    7'b1100011, 3'b000, 0, 1, 3, w_fetch(2), w_decode(2, 0), w_branch(0), '0, '0);
        push("bne_z0",    7'b1100011, 3'b001, 0, 0, 3, w_fetch(2), w_decode(2, 0), w_branch(EXT), '0, '0);
        push("bne_z1",    7'b1100011, 3'b001, 1, 0, 3, w_fetch(2), w_decode(2, 0), w_branch(0), '0, '0);
        push("blt_n1",    7'b1100011, 3'b100, 0, 1, 3, w_fetch(2), w_decode(2, 0), w_branch(EXT), '0, '0);
        push("blt_n0",    7'b1100011, 3'b100, 1, 0, 3, w_fetch(2), w_decode(2, 0), w_branch(0), '0, '0);
        push("bge_n1",    7'b1100011, 3'b101, 0, 1, 3, w_fetch(2), w_decode(2, 0), w_branch(0), '0, '0);
        push("bge_n0",    7'b1100011, 3'b101, 0, 0, 3, w_fetch(2), w_decode(2, 0), w_branch(EXT), '0, '0);
        push("br_f3_010", 7'b1100011, 3'b010, 1, 1, 3, w_fetch(2), w_decode(2, 0), w_branch(0), '0, '0);
        push("illegal",   7'b1111111, 3'b000, 0, 0, 2, w_fetch(0), w_decode(0, 1), '0, '0, '0);
        push("lw_again",  7'b0000011, 3'b000, 1, 1, 5, w_fetch(0), w_decode(0, 0), w_memadr(0), w_memrd(0), w_memwb(0));

        // reset held three cycles: every output low, FETCH outputs included
        rst    = 1'b1;
        opcode = 7'b0110011;
        func3  = 3'b000;
        zero   = 1'b0;
        neg    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", i, '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // instruction table; the first record's cycle 0 is the first FETCH
        for (int i = 0; i < nv; i++) begin
            opcode = vecs[i].op;
            func3  = vecs[i].f3;
            zero   = vecs[i].z;
            neg    = vecs[i].n;
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                @(negedge clk);
                check(vecs[i].name, c, vecs[i].exp[c]);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("back_to_fetch", 0, w_fetch(0));

        // reset during the MEM_WR cycle of a store
        opcode = 7'b0100011;
        func3  = 3'b010;
        @(posedge clk);   // DECODE
        @(posedge clk);   // MEM_ADR
        @(posedge clk);   // MEM_WR
        #1;
        check("sw_memwr_before_rst", 3, w_memwr(1));
        rst = 1'b1;
        #1;
        check("sw_rst_same_cycle", 3, '0);
        @(negedge clk);
        check("sw_rst_held", 4, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", 0, w_fetch(1));
        @(negedge clk);
        check("post_rst_decode", 1, w_decode(1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_main_controller.md
# multicycle_main_controller

Main control FSM of the multi-cycle RV32I core: sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath mux/write-enable and the 2-bit `ALUOp` consumed by the ALU controller, which turns `ALUOp` plus func3/func7 into the ALU operation. Branch resolution uses ALU `zero`/`neg` flags during the branch cycle.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  7  IR[6:0], held by IR register
- `func3`  in  3  IR[14:12]
- `zero`  in  1  ALU result == 0
- `neg`  in  1  ALU result MSB
- `PCWrite`  out  1  PC load enable
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  data memory write
- `IRWrite`  out  1  IR and OldPC load
- `ResultSrc`  out  2  0 = ALUOut, 1 = memory data, 2 = ALU result direct
- `ALUSrcA`  out  2  0 = PC, 1 = OldPC, 2 = register A
- `ALUSrcB`  out  2  0 = register B, 1 = immediate, 2 = constant 4
- `ImmSrc`  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- `RegWrite`  out  1  register file write
- `ALUOp`  out  2  0 = load/store (ADD), 1 = branch (SUB), 2 = R/I type, 3 = U type (LUI)
- `instr_done`  out  1  one-cycle pulse in last cycle of each retired instruction
- `illegal`  out  1  one-cycle pulse in DECODE for unsupported opcode

## Operation
- States and Moore outputs (unlisted outputs 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=0, ALUSrcB=2, ALUOp=0, ResultSrc=2, PCWrite=1 -> DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=1, ALUOp=0 (ALUOut = OldPC+imm). Next by opcode: 0000011/0100011 -> MEM_ADR; 0110011 -> EX_R; 0010011 -> EX_I; 1100011 -> BRANCH; 1101111 -> JUMP; 1100111 -> JALR; 0110111 -> LUI; other -> FETCH with `illegal`=1.
  - MEM_ADR: ALUSrcA=2, ALUSrcB=1, ALUOp=0 -> MEM_RD (load) / MEM_WR (store).
  - MEM_RD: AdrSrc=1, ResultSrc=0 -> MEM_WB.
  - MEM_WB: ResultSrc=1, RegWrite=1, instr_done -> FETCH.
  - MEM_WR: AdrSrc=1, ResultSrc=0, MemWrite=1, instr_done -> FETCH.
  - EX_R: ALUSrcA=2, ALUSrcB=0, ALUOp=2 -> ALU_WB.
  - EX_I: ALUSrcA=2, ALUSrcB=1, ALUOp=2 -> ALU_WB.
  - LUI: ALUSrcB=1, ALUOp=3 -> ALU_WB.
  - ALU_WB: ResultSrc=0, RegWrite=1, instr_done -> FETCH.
  - JALR: ALUSrcA=2, ALUSrcB=1, ALUOp=0 (ALUOut = rs1+imm) -> JUMP.
  - JUMP: ALUSrcA=1, ALUSrcB=2, ALUOp=0, ResultSrc=0, PCWrite=1 (PC <- target in ALUOut, ALU computes OldPC+4) -> ALU_WB.
  - BRANCH: ALUSrcA=2, ALUSrcB=0, ALUOp=1, ResultSrc=0, PCWrite=taken, instr_done -> FETCH.
- `ImmSrc` combinational from `opcode` in every state: load/I/JALR=0, store=1, branch=2, JAL=3, LUI=4, other=0.
- Taken: func3 000 `zero`; 001 `!zero`; 100 `neg`; 101 `!neg`; any other func3 not taken. Signed overflow of SUB ignored (`neg` is raw MSB).
- JALR target LSB not cleared here.

## Timing
- `rst` high: state = FETCH, all outputs forced 0 (including FETCH outputs). First FETCH is the first cycle after deassertion.
- Reset mid-instruction aborts immediately; no partial write completes after `rst` rises.
- Cycle counts: load 5, store 4, R/I 4, LUI 4, JAL 4, JALR 5, branch 3, illegal 2.
- Only `PCWrite` in BRANCH depends combinationally on inputs (`zero`, `neg`, `func3`); all else Moore/opcode-decoded.
- `opcode`/`func3` sampled only after FETCH (IR stable from DECODE onward).

## Configuration
- `BRANCH_EXT_EN` defined: bne/blt/bge decoded as above.
- Not defined: only beq (func3 000) can be taken; all other branch func3 execute as not-taken, still 3 cycles with `instr_done`.

## Structure
- Package `riscv_ctrl_pkg`: opcode constants, state enum, `ALUOp` encoding (LS_W/B_T/RI_T/U_T shared with ALU controller), ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings.
- Sub-module `branch_cond`: combinational func3/zero/neg -> taken, contains the `BRANCH_EXT_EN` guard.

## Test plan
- Reset held 3 cycles with opcode 0110011 -> all outputs 0; release -> FETCH (IRWrite=1, PCWrite=1, ALUSrcB=2), then DECODE.
- lw (0000011) -> states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; RegWrite=1 and ResultSrc=1 only in cycle 5; instr_done once.
- R-type (0110011) -> ALUOp=2, ALUSrcB=0 in cycle 3, RegWrite in cycle 4; LUI (0110111) -> ALUOp=3, ImmSrc=4.
- beq with zero=1 -> PCWrite=1 in cycle 3; zero=0 -> PCWrite=0; blt func3 100, neg=1 -> PCWrite=1 only with `BRANCH_EXT_EN`.
- jalr (1100111) -> JALR then JUMP (PCWrite=1, ALUSrcA=1, ALUSrcB=2) then ALU_WB; 5 cycles total.
- opcode 1111111 -> illegal=1 in DECODE, no RegWrite/MemWrite; rst asserted during MEM_WR cycle -> MemWrite drops same cycle.
